// File: rtl/str_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : str_arbiter_pkg
// Brief  : Shared types and width helpers for the string stream arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package str_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef byte unsigned char_t;

  function automatic int len_w(input int len);
    return $clog2(len + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/str_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : str_arbiter_if
// Brief  : Requester-side and character-stream-side bundle of the arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface str_arbiter_if #(
  parameter int N   = 4,
  parameter int LEN = 16
);
  import str_arbiter_pkg::*;

  localparam int LW = len_w(LEN);
  localparam int SW = idx_w(N);

  logic [N-1:0]         req_vld;
  logic [N-1:0]         req_rdy;
  logic [N*8*LEN-1:0]   req_str;
  logic [N*LW-1:0]      req_len;
  logic                 out_vld;
  logic                 out_rdy;
  char_t                out_dat;
  logic                 out_lst;
  logic [SW-1:0]        out_src;

  // master: the arbiter itself, which owns the output stream
  modport master (
    input  req_vld, req_str, req_len, out_rdy,
    output req_rdy, out_vld, out_dat, out_lst, out_src
  );

  modport slave (
    output req_vld, req_str, req_len, out_rdy,
    input  req_rdy, out_vld, out_dat, out_lst, out_src
  );

endinterface

`default_nettype wire

// File: rtl/str_arbiter_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module : rr_arbiter
// Brief  : Generic round-robin arbiter; one-hot grant plus encoded index.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int N = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic [N-1:0]         i_req,
  input  wire logic                 i_en,
  output logic      [N-1:0]         o_gnt,
  output logic      [$clog2(N)-1:0] o_idx,
  output logic                      o_any
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] r_ptr;
  logic          w_found;
  int            w_j;

  // Search starts at the pointer and wraps, so the last winner gets lowest priority
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!w_found && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = SW'(w_j);
        w_found    = 1'b1;
      end
    end
  end

  assign o_any = w_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (o_idx == SW'(N - 1)) ? '0 : o_idx + SW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/str_arbiter.sv
//------------------------------------------------------------------------------
// Module : str_arbiter
// Brief  : Round-robin string arbiter serialising whole messages onto one byte
//          stream. Define STR_ARBITER_TERM_EN to append a NUL terminator.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module str_arbiter
  import str_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int LEN = 16
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  str_arbiter_if.master bus
);

  localparam int            LW    = len_w(LEN);
  localparam int            SW    = idx_w(N);
  localparam int            SB    = 8 * LEN;
  localparam logic [LW-1:0] C_LEN = LW'(LEN);

  state_t        r_state;
  logic [SB-1:0] r_msg;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] r_lst_idx;
  logic          r_out_vld;
  logic          r_out_lst;
  char_t         r_out_dat;
  logic [SW-1:0] r_out_src;

  logic [N-1:0]  w_gnt;
  logic [SW-1:0] w_idx;
  logic          w_any;
  logic          w_take;
  logic [SB-1:0] w_sel_str;
  logic [LW-1:0] w_sel_raw;
  logic [LW-1:0] w_sel_len;
  logic [LW-1:0] w_sel_lst;
  logic          w_sel_emit;
  logic          w_fire;
  logic [LW-1:0] w_cnt_nxt;

  // Positions at or beyond the message length read as NUL (terminator slot)
  function automatic char_t char_at(input logic [SB-1:0] msg,
                                    input logic [LW-1:0] len,
                                    input logic [LW-1:0] idx);
    logic [SB-1:0] sh;
    sh = msg << (8 * idx);
    return (idx >= len) ? 8'h00 : sh[SB-1 -: 8];
  endfunction

  rr_arbiter #(.N(N)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (bus.req_vld),
    .i_en  (w_take),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_take      = rst_n && (r_state == IDLE) && w_any;
  assign bus.req_rdy = w_take ? w_gnt : '0;

  assign w_sel_str = bus.req_str[int'(w_idx)*SB +: SB];
  assign w_sel_raw = bus.req_len[int'(w_idx)*LW +: LW];
  assign w_sel_len = (w_sel_raw > C_LEN) ? C_LEN : w_sel_raw;

`ifdef STR_ARBITER_TERM_EN
  assign w_sel_emit = 1'b1;
  assign w_sel_lst  = w_sel_len;
`else
  assign w_sel_emit = (w_sel_len != '0);
  assign w_sel_lst  = w_sel_len - LW'(1);
`endif

  assign w_fire    = (r_state == SEND) && r_out_vld && bus.out_rdy;
  assign w_cnt_nxt = r_cnt + LW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_msg     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_lst_idx <= '0;
      r_out_vld <= 1'b0;
      r_out_lst <= 1'b0;
      r_out_dat <= 8'h00;
      r_out_src <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_msg     <= w_sel_str;
            r_len     <= w_sel_len;
            r_lst_idx <= w_sel_lst;
            r_cnt     <= '0;
            r_out_src <= w_idx;
            if (w_sel_emit) begin
              r_state   <= SEND;
              r_out_vld <= 1'b1;
              r_out_dat <= char_at(w_sel_str, w_sel_len, '0);
              r_out_lst <= (w_sel_lst == '0);
            end
          end
        end
        SEND: begin
          if (w_fire) begin
            if (r_cnt == r_lst_idx) begin
              r_state   <= IDLE;
              r_out_vld <= 1'b0;
              r_out_dat <= 8'h00;
              r_out_lst <= 1'b0;
              r_cnt     <= '0;
            end else begin
              r_cnt     <= w_cnt_nxt;
              r_out_dat <= char_at(r_msg, r_len, w_cnt_nxt);
              r_out_lst <= (w_cnt_nxt == r_lst_idx);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_vld = r_out_vld;
  assign bus.out_dat = r_out_dat;
  assign bus.out_lst = r_out_lst;
  assign bus.out_src = r_out_src;

endmodule

`default_nettype wire

// File: tb/tb_str_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_str_arbiter
// Brief  : Directed self-checking bench for str_arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_str_arbiter;
  import str_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int LEN = 16;
  localparam int LW  = len_w(LEN);
  localparam int SW  = idx_w(N);

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  str_arbiter_if #(.N(N), .LEN(LEN)) bus ();

  str_arbiter #(.N(N), .LEN(LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic          rdy;
    logic          lst;
    logic [7:0]    dat;
    logic [SW-1:0] src;
    logic [N-1:0]  acc;
    logic [N-1:0]  rrdy;
  } smp_t;

  smp_t smp[$];

  task automatic set_req(input int i, input string s, input int len);
    for (int c = 0; c < LEN; c++)
      bus.req_str[i*8*LEN + 8*LEN-1 - 8*c -: 8] = (c < s.len()) ? s[c] : 8'h00;
    bus.req_len[i*LW +: LW] = LW'(len);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_rdy always high; mode 1: out_rdy high every third cycle
  task automatic capture(input int ncyc, input int mode, input bit drop);
    smp_t s;
    logic [N-1:0] acc;
    smp.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      bus.out_rdy = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      acc    = bus.req_vld & bus.req_rdy;
      s.vld  = bus.out_vld;
      s.rdy  = bus.out_rdy;
      s.lst  = bus.out_lst;
      s.dat  = bus.out_dat;
      s.src  = bus.out_src;
      s.rrdy = bus.req_rdy;
      s.acc  = acc;
      smp.push_back(s);
      @(posedge clk);
      #1;
      if (drop) bus.req_vld = bus.req_vld & ~acc;
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.req_vld = '1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out_vld !== 1'b0) begin n_errors++; $display("FAIL reset_vld got=%b exp=0", bus.out_vld); end
    n_checks++;
    if (bus.out_dat !== 8'h00) begin n_errors++; $display("FAIL reset_dat got=%h exp=00", bus.out_dat); end
    n_checks++;
    if (bus.out_lst !== 1'b0) begin n_errors++; $display("FAIL reset_lst got=%b exp=0", bus.out_lst); end
    n_checks++;
    if (bus.out_src !== '0) begin n_errors++; $display("FAIL reset_src got=%0d exp=0", bus.out_src); end
    n_checks++;
    if (bus.req_rdy !== '0) begin n_errors++; $display("FAIL reset_req_rdy got=%b exp=0000", bus.req_rdy); end
    bus.req_vld = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    string exp;
    exp = "Hello world!";
    set_req(0, exp, 12);
    bus.req_vld = 4'b0001;
    capture(16, 0, 1'b1);
    n_checks++;
    if (smp[0].acc !== 4'b0001) begin n_errors++; $display("FAIL single_accept got=%b exp=0001", smp[0].acc); end
    for (int i = 1; i <= 12; i++) begin
      n_checks++;
      if (smp[i].vld !== 1'b1 || smp[i].dat !== exp[i-1] || smp[i].lst !== (i == 12) || smp[i].src !== '0) begin
        n_errors++;
        $display("FAIL single_byte%0d got vld=%b dat=%h lst=%b src=%0d exp vld=1 dat=%h lst=%b src=0",
                 i-1, smp[i].vld, smp[i].dat, smp[i].lst, smp[i].src, exp[i-1], (i == 12));
      end
    end
`ifdef STR_ARBITER_TERM_EN
    n_checks++;
    if (smp[13].vld !== 1'b1 || smp[13].dat !== 8'h00 || smp[13].lst !== 1'b1) begin
      n_errors++; $display("FAIL single_nul got vld=%b dat=%h lst=%b exp 1/00/1", smp[13].vld, smp[13].dat, smp[13].lst);
    end
    n_checks++;
    if (smp[14].vld !== 1'b0) begin n_errors++; $display("FAIL single_tail got=%b exp=0", smp[14].vld); end
`else
    n_checks++;
    if (smp[13].vld !== 1'b0 || smp[15].vld !== 1'b0) begin
      n_errors++; $display("FAIL single_tail got=%b%b exp=00", smp[13].vld, smp[15].vld);
    end
`endif
  endtask

  task automatic test_round_robin();
    do_reset();
    set_req(0, "A", 1);
    set_req(1, "B", 1);
    set_req(2, "C", 1);
    set_req(3, "D", 1);
    bus.req_vld = 4'b1111;
`ifdef STR_ARBITER_TERM_EN
    capture(15, 0, 1'b0);
    bus.req_vld = '0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (smp[3*k].acc !== 4'(1 << (k % 4)) || smp[3*k+1].vld !== 1'b1 ||
          smp[3*k+1].dat !== 8'(8'h41 + k % 4) || smp[3*k+1].src !== SW'(k % 4) || smp[3*k+2].dat !== 8'h00) begin
        n_errors++;
        $display("FAIL rr_grant%0d got acc=%b dat=%h src=%0d exp acc=%b dat=%h src=%0d", k, smp[3*k].acc,
                 smp[3*k+1].dat, smp[3*k+1].src, 4'(1 << (k % 4)), 8'(8'h41 + k % 4), k % 4);
      end
    end
`else
    capture(10, 0, 1'b0);
    bus.req_vld = '0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (smp[2*k].vld !== 1'b0 || smp[2*k].acc !== 4'(1 << (k % 4)) || smp[2*k+1].vld !== 1'b1 ||
          smp[2*k+1].dat !== 8'(8'h41 + k % 4) || smp[2*k+1].src !== SW'(k % 4) || smp[2*k+1].lst !== 1'b1) begin
        n_errors++;
        $display("FAIL rr_grant%0d got idle_vld=%b acc=%b dat=%h src=%0d lst=%b exp 0/%b/%h/%0d/1", k,
                 smp[2*k].vld, smp[2*k].acc, smp[2*k+1].dat, smp[2*k+1].src, smp[2*k+1].lst,
                 4'(1 << (k % 4)), 8'(8'h41 + k % 4), k % 4);
      end
    end
`endif
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_empty();
    int pulses;
    set_req(2, "", 0);
    bus.req_vld = 4'b0100;
    capture(5, 0, 1'b1);
    pulses = 0;
    foreach (smp[i]) if (smp[i].rrdy !== '0) pulses++;
    n_checks++;
    if (smp[0].acc !== 4'b0100 || pulses !== 1) begin
      n_errors++; $display("FAIL empty_rdy got acc=%b pulses=%0d exp acc=0100 pulses=1", smp[0].acc, pulses);
    end
`ifdef STR_ARBITER_TERM_EN
    n_checks++;
    if (smp[1].vld !== 1'b1 || smp[1].dat !== 8'h00 || smp[1].lst !== 1'b1 || smp[1].src !== SW'(2) || smp[2].vld !== 1'b0) begin
      n_errors++; $display("FAIL empty_nul got vld=%b dat=%h lst=%b src=%0d next=%b exp 1/00/1/2/0",
                           smp[1].vld, smp[1].dat, smp[1].lst, smp[1].src, smp[2].vld);
    end
`else
    n_checks++;
    if (smp[1].vld !== 1'b0 || smp[2].vld !== 1'b0 || smp[4].vld !== 1'b0) begin
      n_errors++; $display("FAIL empty_novld got=%b%b%b exp=000", smp[1].vld, smp[2].vld, smp[4].vld);
    end
`endif
  endtask

  task automatic test_stall();
    string exp;
    int    nb;
    int    b;
    logic [7:0] e;
    exp = "Finish.";
`ifdef STR_ARBITER_TERM_EN
    nb = 8;
`else
    nb = 7;
`endif
    set_req(1, exp, 7);
    bus.req_vld = 4'b0010;
    capture(30, 1, 1'b1);
    b = 0;
    for (int i = 1; i < 30; i++) begin
      if (smp[i].vld === 1'b1) begin
        e = (b < 7) ? exp[b] : 8'h00;
        n_checks++;
        if (b >= nb || smp[i].dat !== e || smp[i].src !== SW'(1) || smp[i].lst !== (b == nb - 1)) begin
          n_errors++;
          $display("FAIL stall_cycle%0d got dat=%h src=%0d lst=%b exp dat=%h src=1 lst=%b byte=%0d",
                   i, smp[i].dat, smp[i].src, smp[i].lst, e, (b == nb - 1), b);
        end
        if (smp[i].rdy) b++;
      end
    end
    n_checks++;
    if (b !== nb) begin n_errors++; $display("FAIL stall_count got=%0d exp=%0d", b, nb); end
    bus.out_rdy = 1'b1;
  endtask

  task automatic test_clip();
    string exp;
    int    tail;
    exp = "ABCDEFGHIJKLMNOP";
    set_req(0, exp, 20);
    bus.req_vld = 4'b0001;
    capture(20, 0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      n_checks++;
`ifdef STR_ARBITER_TERM_EN
      if (smp[i].vld !== 1'b1 || smp[i].dat !== exp[i-1] || smp[i].lst !== 1'b0) begin
`else
      if (smp[i].vld !== 1'b1 || smp[i].dat !== exp[i-1] || smp[i].lst !== (i == 16)) begin
`endif
        n_errors++;
        $display("FAIL clip_byte%0d got vld=%b dat=%h lst=%b exp dat=%h", i-1, smp[i].vld, smp[i].dat, smp[i].lst, exp[i-1]);
      end
    end
`ifdef STR_ARBITER_TERM_EN
    n_checks++;
    if (smp[17].vld !== 1'b1 || smp[17].dat !== 8'h00 || smp[17].lst !== 1'b1) begin
      n_errors++; $display("FAIL clip_nul got vld=%b dat=%h lst=%b exp 1/00/1", smp[17].vld, smp[17].dat, smp[17].lst);
    end
    tail = 18;
`else
    tail = 17;
`endif
    n_checks++;
    if (smp[tail].vld !== 1'b0) begin n_errors++; $display("FAIL clip_tail got=%b exp=0", smp[tail].vld); end
  endtask

  task automatic test_reset_mid();
    set_req(0, "Hello world!", 12);
    bus.req_vld = 4'b0001;
    bus.out_rdy = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (bus.out_vld !== 1'b1 || bus.out_dat !== 8'h6f) begin
      n_errors++; $display("FAIL midrst_byte4 got vld=%b dat=%h exp 1/6f", bus.out_vld, bus.out_dat);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_vld !== 1'b0 || bus.out_dat !== 8'h00 || bus.out_lst !== 1'b0 || bus.req_rdy !== '0) begin
      n_errors++; $display("FAIL midrst_async got vld=%b dat=%h lst=%b rdy=%b exp 0/00/0/0000",
                           bus.out_vld, bus.out_dat, bus.out_lst, bus.req_rdy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    capture(3, 0, 1'b0);
    n_checks++;
    if (smp[0].vld !== 1'b1 || smp[0].dat !== 8'h48 || smp[0].src !== '0 ||
        smp[1].dat !== 8'h65 || smp[2].dat !== 8'h6c) begin
      n_errors++; $display("FAIL midrst_restart got vld=%b dat=%h,%h,%h src=%0d exp 1 48,65,6c src=0",
                           smp[0].vld, smp[0].dat, smp[1].dat, smp[2].dat, smp[0].src);
    end
    bus.req_vld = '0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    bus.req_vld = '0;
    bus.req_str = '0;
    bus.req_len = '0;
    bus.out_rdy = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_empty();
    test_stall();
    test_clip();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
